// File: rtl/cnn_layer_accel_sys_mem_pkg.sv
// Shared types and helpers for the system-memory responder: FSM state enums and
// beat/index sizing functions used by the top and the arbiter.
package cnn_layer_accel_sys_mem_pkg;

  typedef enum logic [2:0] {RdIdle, RdAck, RdFetch, RdData, RdCmpl} read_state_t;
  typedef enum logic [1:0] {WrIdle, WrAck, WrData, WrCmpl} write_state_t;

  localparam int unsigned BitsPerByte = 8;

  // log2 of the beat size in bytes; byte address >> this gives the beat number.
  function automatic int unsigned beat_shift(input int unsigned data_wth);
    return $clog2(data_wth / BitsPerByte);
  endfunction

  function automatic int unsigned id_width(input int unsigned num_id);
    return (num_id > 1) ? $clog2(num_id) : 1;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_rr_arb.sv
// Round-robin arbiter: searches from the registered pointer and, once a grant is
// taken, moves the pointer just past the granted requester.
module cnn_layer_accel_rr_arb
  import cnn_layer_accel_sys_mem_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdW = id_width(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              take_i,
  output logic              gnt_vld_o,
  output logic [IdW-1:0]    gnt_id_o
);

  logic [IdW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned cand;
    cand      = 0;
    gnt_vld_o = 1'b0;
    gnt_id_o  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = (32'(ptr_q) + i) % NumReq;
      if (!gnt_vld_o && req_i[IdW'(cand)]) begin
        gnt_vld_o = 1'b1;
        gnt_id_o  = IdW'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take_i && gnt_vld_o) begin
      ptr_d = (32'(gnt_id_o) + 32'd1 >= NumReq) ? '0 : gnt_id_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cnn_layer_accel_sys_mem_rsp.sv
// System-memory responder model: multi-ID round-robin read engine and a single
// write engine sharing a simple dual-port beat store.
module cnn_layer_accel_sys_mem_rsp
  import cnn_layer_accel_sys_mem_pkg::*;
#(
  parameter int unsigned C_NUM_RD_ID = 4,
  parameter int unsigned C_ADDR_WTH  = 32,
  parameter int unsigned C_LEN_WTH   = 16,
  parameter int unsigned C_DATA_WTH  = 512,
  parameter int unsigned C_MEM_DEPTH = 4096
) (
  input  logic                              clk_intf,
  input  logic                              rst,
  input  logic [C_NUM_RD_ID-1:0]            sys_mem_read_req,
  input  logic [C_NUM_RD_ID*C_ADDR_WTH-1:0] sys_mem_read_addr,
  input  logic [C_NUM_RD_ID*C_LEN_WTH-1:0]  sys_mem_read_len,
  output logic [C_NUM_RD_ID-1:0]            sys_mem_read_req_ack,
  output logic [C_NUM_RD_ID-1:0]            sys_mem_read_in_prog,
  output logic [C_DATA_WTH-1:0]             sys_mem_read_data,
  output logic                              sys_mem_read_data_vld,
  input  logic [C_NUM_RD_ID-1:0]            sys_mem_read_data_rdy,
  output logic [C_NUM_RD_ID-1:0]            sys_mem_read_cmpl,
  input  logic                              sys_mem_write_req,
  input  logic [C_ADDR_WTH-1:0]             sys_mem_write_addr,
  input  logic [C_LEN_WTH-1:0]              sys_mem_write_len,
  output logic                              sys_mem_write_req_ack,
  output logic                              sys_mem_write_in_prog,
  input  logic [C_DATA_WTH-1:0]             sys_mem_write_data,
  input  logic                              sys_mem_write_data_vld,
  output logic                              sys_mem_write_data_rdy,
  output logic                              sys_mem_write_cmpl
);

  localparam int unsigned IdW       = id_width(C_NUM_RD_ID);
  localparam int unsigned IdxW      = $clog2(C_MEM_DEPTH);
  localparam int unsigned BeatShift = beat_shift(C_DATA_WTH);

  // Depth is a power of two, so truncating the beat number gives the mod.
  function automatic logic [IdxW-1:0] to_idx(input logic [C_ADDR_WTH-1:0] addr);
    return IdxW'(addr >> BeatShift);
  endfunction

  logic [C_DATA_WTH-1:0] mem_q [C_MEM_DEPTH];
  logic [C_DATA_WTH-1:0] rd_data_q;
  logic                  mem_re, mem_we;

  read_state_t            rd_state_q, rd_state_d;
  logic [IdW-1:0]         rd_id_q, rd_id_d;
  logic [IdxW-1:0]        rd_idx_q, rd_idx_d;
  logic [C_LEN_WTH-1:0]   rd_rem_q, rd_rem_d;
  logic [C_NUM_RD_ID-1:0] rd_ack_q, rd_ack_d, rd_prog_q, rd_prog_d, rd_cmpl_q, rd_cmpl_d;
  logic                   rd_vld_q, rd_vld_d, rd_xfer;
  logic                   arb_vld, arb_take;
  logic [IdW-1:0]         arb_id;

  write_state_t         wr_state_q, wr_state_d;
  logic [IdxW-1:0]      wr_idx_q, wr_idx_d;
  logic [C_LEN_WTH-1:0] wr_rem_q, wr_rem_d;
  logic                 wr_ack_q, wr_ack_d, wr_prog_q, wr_prog_d;
  logic                 wr_rdy_q, wr_rdy_d, wr_cmpl_q, wr_cmpl_d;

  cnn_layer_accel_rr_arb #(
    .NumReq (C_NUM_RD_ID)
  ) u_rr_arb (
    .clk_i     (clk_intf),
    .rst_i     (rst),
    .req_i     (sys_mem_read_req),
    .take_i    (arb_take),
    .gnt_vld_o (arb_vld),
    .gnt_id_o  (arb_id)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_idx_d   = rd_idx_q;
    rd_rem_d   = rd_rem_q;
    rd_ack_d   = '0;
    rd_prog_d  = rd_prog_q;
    rd_cmpl_d  = '0;
    rd_vld_d   = rd_vld_q;
    mem_re     = 1'b0;
    arb_take   = 1'b0;
    rd_xfer    = rd_vld_q && sys_mem_read_data_rdy[rd_id_q];
    unique case (rd_state_q)
      RdIdle: begin
        if (arb_vld) begin
          arb_take          = 1'b1;
          rd_id_d           = arb_id;
          rd_idx_d          = to_idx(sys_mem_read_addr[32'(arb_id) * C_ADDR_WTH +: C_ADDR_WTH]);
          rd_rem_d          = sys_mem_read_len[32'(arb_id) * C_LEN_WTH +: C_LEN_WTH];
          rd_ack_d[arb_id]  = 1'b1;
          rd_prog_d[arb_id] = 1'b1;
          rd_state_d        = RdAck;
        end
      end
      RdAck: begin
        if (rd_rem_q == '0) begin
          rd_prog_d          = '0;
          rd_cmpl_d[rd_id_q] = 1'b1;
          rd_state_d         = RdCmpl;
        end else begin
          rd_state_d = RdFetch;
        end
      end
      RdFetch: begin
        mem_re     = 1'b1;
        rd_idx_d   = rd_idx_q + 1'b1;
        rd_vld_d   = 1'b1;
        rd_state_d = RdData;
      end
      RdData: begin
        if (rd_xfer) begin
          if (rd_rem_q == C_LEN_WTH'(1)) begin
            rd_vld_d           = 1'b0;
            rd_prog_d          = '0;
            rd_cmpl_d[rd_id_q] = 1'b1;
            rd_state_d         = RdCmpl;
          end else begin
            // Prefetch the next beat on the same edge so rdy-high streams 1 beat/cycle.
            mem_re   = 1'b1;
            rd_idx_d = rd_idx_q + 1'b1;
            rd_rem_d = rd_rem_q - 1'b1;
          end
        end
      end
      RdCmpl:  rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_rem_d   = wr_rem_q;
    wr_ack_d   = 1'b0;
    wr_prog_d  = wr_prog_q;
    wr_rdy_d   = wr_rdy_q;
    wr_cmpl_d  = 1'b0;
    mem_we     = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        if (sys_mem_write_req) begin
          wr_idx_d   = to_idx(sys_mem_write_addr);
          wr_rem_d   = sys_mem_write_len;
          wr_ack_d   = 1'b1;
          wr_state_d = WrAck;
        end
      end
      WrAck: begin
        if (wr_rem_q == '0) begin
          wr_cmpl_d  = 1'b1;
          wr_state_d = WrCmpl;
        end else begin
          wr_prog_d  = 1'b1;
          wr_rdy_d   = 1'b1;
          wr_state_d = WrData;
        end
      end
      WrData: begin
        if (sys_mem_write_data_vld && wr_rdy_q) begin
          mem_we   = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          wr_rem_d = wr_rem_q - 1'b1;
          if (wr_rem_q == C_LEN_WTH'(1)) begin
            wr_rdy_d   = 1'b0;
            wr_prog_d  = 1'b0;
            wr_cmpl_d  = 1'b1;
            wr_state_d = WrCmpl;
          end
        end
      end
      WrCmpl:  wr_state_d = WrIdle;
      default: wr_state_d = WrIdle;
    endcase
  end

  // Store is never reset; a read of the index being written returns the old word.
  always_ff @(posedge clk_intf) begin
    if (mem_we && !rst) mem_q[wr_idx_q] <= sys_mem_write_data;
  end

  always_ff @(posedge clk_intf) begin
    if (rst)         rd_data_q <= '0;
    else if (mem_re) rd_data_q <= mem_q[rd_idx_q];
  end

  always_ff @(posedge clk_intf) begin
    if (rst) begin
      rd_state_q <= RdIdle;
      rd_id_q    <= '0;
      rd_idx_q   <= '0;
      rd_rem_q   <= '0;
      rd_ack_q   <= '0;
      rd_prog_q  <= '0;
      rd_cmpl_q  <= '0;
      rd_vld_q   <= 1'b0;
      wr_state_q <= WrIdle;
      wr_idx_q   <= '0;
      wr_rem_q   <= '0;
      wr_ack_q   <= 1'b0;
      wr_prog_q  <= 1'b0;
      wr_rdy_q   <= 1'b0;
      wr_cmpl_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_idx_q   <= rd_idx_d;
      rd_rem_q   <= rd_rem_d;
      rd_ack_q   <= rd_ack_d;
      rd_prog_q  <= rd_prog_d;
      rd_cmpl_q  <= rd_cmpl_d;
      rd_vld_q   <= rd_vld_d;
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_rem_q   <= wr_rem_d;
      wr_ack_q   <= wr_ack_d;
      wr_prog_q  <= wr_prog_d;
      wr_rdy_q   <= wr_rdy_d;
      wr_cmpl_q  <= wr_cmpl_d;
    end
  end

  assign sys_mem_read_req_ack   = rd_ack_q;
  assign sys_mem_read_in_prog   = rd_prog_q;
  assign sys_mem_read_data      = rd_data_q;
  assign sys_mem_read_data_vld  = rd_vld_q;
  assign sys_mem_read_cmpl      = rd_cmpl_q;
  assign sys_mem_write_req_ack  = wr_ack_q;
  assign sys_mem_write_in_prog  = wr_prog_q;
  assign sys_mem_write_data_rdy = wr_rdy_q;
  assign sys_mem_write_cmpl     = wr_cmpl_q;

endmodule

// File: tb/tb_cnn_layer_accel_sys_mem_rsp.sv
// Directed bench for the system-memory responder: a table of write/read
// transactions with hand-computed beats, plus arbitration and reset sequences.
module tb_cnn_layer_accel_sys_mem_rsp;

  localparam int unsigned NRd = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 16;
  localparam int unsigned DW  = 512;

  logic              clk_intf = 1'b0;
  logic              rst;
  logic [NRd-1:0]    rd_req, rd_ack, rd_prog, rd_rdy, rd_cmpl;
  logic [NRd*AW-1:0] rd_addr;
  logic [NRd*LW-1:0] rd_len;
  logic [DW-1:0]     rd_data, wr_data;
  logic              rd_vld;
  logic              wr_req, wr_ack, wr_prog, wr_vld, wr_rdy, wr_cmpl;
  logic [AW-1:0]     wr_addr;
  logic [LW-1:0]     wr_len;

  always #5 clk_intf = ~clk_intf;

  cnn_layer_accel_sys_mem_rsp dut (
    .clk_intf               (clk_intf),
    .rst                    (rst),
    .sys_mem_read_req       (rd_req),
    .sys_mem_read_addr      (rd_addr),
    .sys_mem_read_len       (rd_len),
    .sys_mem_read_req_ack   (rd_ack),
    .sys_mem_read_in_prog   (rd_prog),
    .sys_mem_read_data      (rd_data),
    .sys_mem_read_data_vld  (rd_vld),
    .sys_mem_read_data_rdy  (rd_rdy),
    .sys_mem_read_cmpl      (rd_cmpl),
    .sys_mem_write_req      (wr_req),
    .sys_mem_write_addr     (wr_addr),
    .sys_mem_write_len      (wr_len),
    .sys_mem_write_req_ack  (wr_ack),
    .sys_mem_write_in_prog  (wr_prog),
    .sys_mem_write_data     (wr_data),
    .sys_mem_write_data_vld (wr_vld),
    .sys_mem_write_data_rdy (wr_rdy),
    .sys_mem_write_cmpl     (wr_cmpl)
  );

  typedef struct {
    bit              is_wr;
    int              id;
    logic [AW-1:0]   addr;
    int              len;
    logic [3:0][31:0] tags;
    logic [7:0]      pat;
  } vec_t;

  vec_t vecs [10];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input logic [31:0] tag);
    return {16{tag}};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_ack"}, int'(rd_ack), 0);
    chk({tag, "_rd_prog"}, int'(rd_prog), 0);
    chk_d({tag, "_rd_data"}, rd_data, '0);
    chk({tag, "_rd_vld"}, int'(rd_vld), 0);
    chk({tag, "_rd_cmpl"}, int'(rd_cmpl), 0);
    chk({tag, "_wr_ack"}, int'(wr_ack), 0);
    chk({tag, "_wr_prog"}, int'(wr_prog), 0);
    chk({tag, "_wr_rdy"}, int'(wr_rdy), 0);
    chk({tag, "_wr_cmpl"}, int'(wr_cmpl), 0);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [3:0][31:0] tags);
    int t, acc, cmpl_at, last_at;
    bit rdy_seen, pend;
    acc = 0; cmpl_at = -1; last_at = 0; rdy_seen = 0; pend = 0; t = 0;
    wr_req = 1'b1; wr_addr = addr; wr_len = LW'(len);
    do begin @(negedge clk_intf); t++; end while (!wr_ack && t < 20);
    chk("wr_ack_seen", int'(wr_ack), 1);
    chk("wr_rdy_in_ack", int'(wr_rdy), 0);
    wr_req = 1'b0;
    wr_vld = (len > 0);
    wr_data = beat(tags[0]);
    for (int c = 1; c <= len + 6; c++) begin
      @(negedge clk_intf);
      if (pend) begin
        acc++;
        if (acc < len) wr_data = beat(tags[acc]);
        else wr_vld = 1'b0;
        pend = 1'b0;
      end
      if (wr_rdy) rdy_seen = 1'b1;
      if (c == 1 && len > 0) begin
        chk("wr_rdy_after_ack", int'(wr_rdy), 1);
        chk("wr_prog_after_ack", int'(wr_prog), 1);
      end
      if (wr_cmpl) begin
        cmpl_at = c;
        chk("wr_prog_at_cmpl", int'(wr_prog), 0);
        chk("wr_rdy_at_cmpl", int'(wr_rdy), 0);
        break;
      end
      if (wr_vld && wr_rdy) begin
        pend = 1'b1;
        last_at = c;
      end
    end
    wr_vld = 1'b0;
    chk("wr_beats", acc, len);
    chk("wr_cmpl_cycle", cmpl_at, last_at + 1);
    if (len == 0) chk("wr_rdy_never", int'(rdy_seen), 0);
  endtask

  task automatic do_read(input int id, input logic [AW-1:0] addr, input int len,
                         input logic [7:0] pat, input logic [3:0][31:0] tags,
                         input logic [NRd-1:0] extra);
    int t, got, first_vld, cmpl_at, last_at;
    logic [NRd-1:0] me;
    bit r;
    me = NRd'(1 << id);
    t = 0; got = 0; first_vld = -1; cmpl_at = -1; last_at = 0;
    rd_addr[id*AW +: AW] = addr;
    rd_len[id*LW +: LW]  = LW'(len);
    rd_rdy = '0;
    rd_req = extra | me;
    do begin @(negedge clk_intf); t++; end while (rd_ack == '0 && t < 20);
    chk("rd_ack_id", int'(rd_ack), int'(me));
    chk("rd_prog_in_ack", int'(rd_prog), int'(me));
    rd_req = '0;
    for (int c = 1; c <= len + 20; c++) begin
      @(negedge clk_intf);
      if (rd_cmpl != '0) begin
        cmpl_at = c;
        chk("rd_cmpl_id", int'(rd_cmpl), int'(me));
        chk("rd_prog_at_cmpl", int'(rd_prog), 0);
        chk("rd_vld_at_cmpl", int'(rd_vld), 0);
        break;
      end
      r = (c >= 2) ? pat[(c - 2) % 8] : 1'b0;
      // Other IDs' rdy driven opposite to ours; the responder must ignore them.
      rd_rdy = r ? me : ~me;
      if (rd_vld) begin
        if (first_vld < 0) first_vld = c;
        if (got < len) chk_d("rd_data", rd_data, beat(tags[got]));
        else chk("rd_extra_beat", got, len - 1);
        if (r) begin
          got++;
          last_at = c;
        end
      end
    end
    rd_rdy = '0;
    chk("rd_beats", got, len);
    chk("rd_first_vld", first_vld, (len == 0) ? -1 : 2);
    chk("rd_cmpl_cycle", cmpl_at, (len == 0) ? 1 : last_at + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, got, n, overlap;
    bit busy, hit;
    int rr_got [4];
    int rr_exp [4];

    vecs[0] = '{1'b1, 0, 32'h0,     4, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'hFF};
    vecs[1] = '{1'b0, 2, 32'h0,     4, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'hFF};
    vecs[2] = '{1'b0, 1, 32'h0,     4, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'hF9};
    vecs[3] = '{1'b1, 0, 32'h3FFC0, 3, {32'h0,  32'hB2, 32'hB1, 32'hB0}, 8'hFF};
    vecs[4] = '{1'b0, 0, 32'h3FFC0, 3, {32'h0,  32'hB2, 32'hB1, 32'hB0}, 8'hFF};
    vecs[5] = '{1'b0, 3, 32'h0,     2, {32'h0,  32'h0,  32'hB2, 32'hB1}, 8'h55};
    vecs[6] = '{1'b0, 1, 32'h80,    2, {32'h0,  32'h0,  32'hA3, 32'hA2}, 8'hFF};
    vecs[7] = '{1'b0, 0, 32'h0,     0, {32'h0,  32'h0,  32'h0,  32'h0},  8'hFF};
    vecs[8] = '{1'b1, 0, 32'h40,    0, {32'h0,  32'h0,  32'h0,  32'hEE}, 8'hFF};
    vecs[9] = '{1'b0, 3, 32'h7F,    1, {32'h0,  32'h0,  32'h0,  32'hB2}, 8'hFF};
    rr_exp = '{1, 2, 8, 1};

    rst = 1'b1;
    rd_req = '0; rd_addr = '0; rd_len = '0; rd_rdy = '0;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_data = '0; wr_vld = 1'b0;
    repeat (3) @(negedge clk_intf);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk_intf);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].len, vecs[i].tags);
      else do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].pat, vecs[i].tags, '0);
      @(negedge clk_intf);
    end

    // Round-robin with IDs 0, 1 and 3 requesting continuously.
    rd_addr = '0; rd_len = '0; rd_req = 4'b1011;
    n = 0; overlap = 0; busy = 1'b0;
    rr_got = '{0, 0, 0, 0};
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk_intf);
      if (rd_ack != '0) begin
        if (busy) overlap++;
        busy = 1'b1;
        rr_got[n] = int'(rd_ack);
        n++;
      end
      if (rd_cmpl != '0) busy = 1'b0;
    end
    rd_req = '0;
    for (int k = 0; k < 4; k++) chk("rr_grant", rr_got[k], rr_exp[k]);
    chk("rr_overlap", overlap, 0);
    repeat (5) @(negedge clk_intf);

    // Reset while read beat 2 is presented and a write sits waiting for data.
    rd_addr = '0; rd_len = '0;
    rd_len[0 +: LW] = 16'd4;
    rd_rdy = 4'b0001; rd_req = 4'b0001;
    wr_addr = 32'h1000; wr_len = 16'd2; wr_vld = 1'b0; wr_req = 1'b1;
    t = 0;
    do begin @(negedge clk_intf); t++; end while (rd_ack == '0 && t < 20);
    rd_req = '0; wr_req = 1'b0;
    chk("rst_seq_ack", int'(rd_ack), 1);
    got = 0; hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_intf);
      if (rd_vld) begin
        if (got == 2) begin
          hit = 1'b1;
          break;
        end
        got++;
      end
    end
    chk("rst_seq_beat2", int'(hit), 1);
    chk("wr_busy_before_rst", int'(wr_rdy), 1);
    rst = 1'b1;
    @(negedge clk_intf);
    chk_all_zero("midrst");
    rst = 1'b0;
    rd_rdy = '0;
    @(negedge clk_intf);
    // Pointer is back at 0, so ID0 wins over ID3; store contents survive reset.
    rd_len[3*LW +: LW] = 16'd0;
    do_read(0, 32'h80, 2, 8'hFF, {32'h0, 32'h0, 32'hA3, 32'hA2}, 4'b1000);
    repeat (3) @(negedge clk_intf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_sys_mem_rsp.md
CNN_LAYER_ACCEL_SYS_MEM_RSP -- requirements
Module: cnn_layer_accel_sys_mem_rsp

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- C_NUM_RD_ID, 4: number of read requester IDs.
- C_ADDR_WTH, 32: byte-address width.
- C_LEN_WTH, 16: length width, counted in data beats.
- C_DATA_WTH, 512: beat width in bits.
- C_MEM_DEPTH, 4096: backing-store depth in beats, power of two.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_intf, in, 1: the only clock.
- rst, in, 1: synchronous, active-high reset.
- sys_mem_read_req, in, C_NUM_RD_ID: per-ID read request level.
- sys_mem_read_addr, in, C_NUM_RD_ID*C_ADDR_WTH: per-ID start address; ID i occupies slice i.
- sys_mem_read_len, in, C_NUM_RD_ID*C_LEN_WTH: per-ID beat count.
- sys_mem_read_req_ack, out, C_NUM_RD_ID: one-cycle grant pulse.
- sys_mem_read_in_prog, out, C_NUM_RD_ID: granted ID is being served.
- sys_mem_read_data, out, C_DATA_WTH: read beat.
- sys_mem_read_data_vld, out, 1: read beat valid.
- sys_mem_read_data_rdy, in, C_NUM_RD_ID: per-ID sink ready.
- sys_mem_read_cmpl, out, C_NUM_RD_ID: one-cycle completion pulse.
- sys_mem_write_req, in, 1: write request level.
- sys_mem_write_addr, in, C_ADDR_WTH: write start address.
- sys_mem_write_len, in, C_LEN_WTH: write beat count.
- sys_mem_write_req_ack, out, 1: grant pulse.
- sys_mem_write_in_prog, out, 1: write being served.
- sys_mem_write_data, in, C_DATA_WTH: write beat.
- sys_mem_write_data_vld, in, 1: write beat valid.
- sys_mem_write_data_rdy, out, 1: responder accepts beats.
- sys_mem_write_cmpl, out, 1: one-cycle completion pulse.
REQ-003 One clock (clk_intf); reset rst is synchronous and active-high.

Function
REQ-004 Beat index = (addr / (C_DATA_WTH/8)) mod C_MEM_DEPTH; the index increments per beat and wraps at C_MEM_DEPTH-1 -> 0.
REQ-005 Read and write engines are independent and may be active in the same cycle; the backing store is simple dual-port.
REQ-006 Read FSM states: IDLE, ACK, FETCH, DATA, CMPL.
REQ-007 IDLE: when any read_req bit is set, grant one ID round-robin, starting after the last granted ID (ID 0 first after reset); latch that ID's addr and len; go to ACK.
REQ-008 ACK: req_ack[id]=1 for exactly this cycle; in_prog[id] rises this cycle and holds until CMPL.
REQ-009 FETCH: issue the store read (1-cycle latency); first read_data_vld occurs 2 cycles after the req_ack cycle.
REQ-010 DATA: a beat transfers when read_data_vld && read_data_rdy[id]. With rdy low, vld and data stay stable. Back-to-back beats are sustained at 1 beat/cycle while rdy is high. rdy bits of other IDs are ignored.
REQ-011 After the last beat transfers: in_prog[id] falls and cmpl[id]=1 for one cycle (CMPL) on the next cycle; then return to IDLE. The next grant is no earlier than the cycle after CMPL.
REQ-012 Read len=0: ACK, then CMPL on the next cycle; no vld beats.
REQ-013 Write FSM states: IDLE, ACK, DATA, CMPL.
REQ-014 Write ACK: req_ack pulses 1 cycle; in_prog and data_rdy rise on the next cycle.
REQ-015 Write DATA: a beat is written when write_data_vld && write_data_rdy. After the last beat, data_rdy and in_prog fall and cmpl pulses on the next cycle.
REQ-016 Write len=0: ACK -> CMPL, with data_rdy never asserted.
REQ-017 A read of an index written in the same cycle returns old data.
REQ-018 Request levels that drop after a grant are ignored; the latched transaction runs to completion.

Reset
REQ-019 rst aborts any in-flight transaction. On the next edge, both FSMs are IDLE, the round-robin pointer is 0, and every output is 0 (read_data included).
REQ-020 Backing-store contents are not cleared by rst.

Structure
REQ-021 A shared package cnn_layer_accel_sys_mem_pkg holds the read_state_t and write_state_t enums and beat-width/index helper constants.
REQ-022 The round-robin arbiter is a sub-module, cnn_layer_accel_rr_arb, parameterised by requester count, with a registered grant pointer.

Verification
REQ-023 Write ID-less: addr 0x0, len 4, beats A0..A3 with vld always high -> ack at T, rdy at T+1, 4 beats accepted, cmpl one cycle after last beat.
REQ-024 Read ID 2: addr 0x0, len 4, rdy[2]=1 -> ack[2] at T, vld at T+2..T+5 with A0..A3, cmpl[2] at T+6.
REQ-025 Read ID 1 with rdy[1] toggling 1,0,0,1 -> data held stable while rdy low; all 4 beats delivered in order exactly once.
REQ-026 read_req=4'b1011 held continuously -> grants in order ID0, ID1, ID3, ID0; grants never overlap.
REQ-027 Write len 3 at beat index C_MEM_DEPTH-1, then read back -> indices 4095, 0, 1 hold the data; read len 0 -> ack then cmpl, no vld.
REQ-028 rst asserted mid-read on beat 2 -> all outputs 0 next cycle; a new request after rst is served correctly.
